// File: rtl/breakpoint_unit.sv
// Breakpoint comparator feeding the clock/halt controller.
// Holds NUM_BP PC breakpoint slots and compares them on the first cycle of
// each new instruction. A hit pulls o_breakpointHitN low until the operator
// steps the CPU or disables breakpoints. The hitting instruction is then
// allowed to finish before compares are re-armed.
//
// state | meaning
// ------+-----------------------------------------------------------------
// ARMED | compares active, hitN=1
// HIT   | breakpoint taken, hitN=0, waiting for a step or a disable
// SKIP  | hitN=1, compares ignored until the hitting instruction finishes
module breakpoint_unit #(
    parameter int ADDR_WIDTH    = 16,
    parameter int NUM_BP        = 4,
    parameter int HIT_CNT_WIDTH = 8,
    localparam int IDX_W        = $clog2(NUM_BP)
) (
    input  logic                     i_clk,
    input  logic                     i_resetn,
    input  logic                     i_breakpointEnableN,
    input  logic                     i_cpuRun,
    input  logic                     i_ctrlInstrFinishedN,
    input  logic [ADDR_WIDTH-1:0]    i_pc,
    input  logic                     i_cfgWe,
    input  logic [IDX_W-1:0]         i_cfgIdx,
    input  logic [ADDR_WIDTH-1:0]    i_cfgAddr,
    input  logic                     i_cfgValid,
    input  logic                     i_cntClr,
    output logic                     o_breakpointHitN,
    output logic [IDX_W-1:0]         o_hitIdx,
    output logic [HIT_CNT_WIDTH-1:0] o_hitCount
);

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        HIT   = 2'd1,
        SKIP  = 2'd2
    } state_t;

    state_t                     r_state;
    logic                       r_hitN;
    logic [IDX_W-1:0]           r_hitIdx;
    logic [HIT_CNT_WIDTH-1:0]   r_hitCount;
    logic                       r_fetchStrobe;
    logic [ADDR_WIDTH-1:0]      r_slotAddr [NUM_BP];
    logic [NUM_BP-1:0]          r_slotValid;

    logic                       w_instrDone;
    logic                       w_match;
    logic [IDX_W-1:0]           w_matchIdx;
    logic                       w_hitEvent;
    logic                       w_leaveHit;

    // An instruction retires on a cycle where the CPU advances through its last micro-step.
    assign w_instrDone = ~i_ctrlInstrFinishedN & i_cpuRun;
    assign w_hitEvent  = (r_state == ARMED) & r_fetchStrobe & w_match & ~i_breakpointEnableN;
    assign w_leaveHit  = i_cpuRun | i_breakpointEnableN;

    // Mark the first cycle of the next instruction, the only cycle i_pc is compared.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_fetchStrobe <= 1'b0;
        end else begin
            r_fetchStrobe <= w_instrDone;
        end
    end

    // Slot storage; a write lands at the edge, so same-cycle compares see the old contents.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_slotValid <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                r_slotAddr[i] <= '0;
            end
        end else if (i_cfgWe) begin
            r_slotAddr[i_cfgIdx]  <= i_cfgAddr;
            r_slotValid[i_cfgIdx] <= i_cfgValid;
        end
    end

    // Compare all slots; scanning downward lets the lowest matching index win.
    always_comb begin
        w_match    = 1'b0;
        w_matchIdx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (r_slotValid[i] && (r_slotAddr[i] == i_pc)) begin
                w_match    = 1'b1;
                w_matchIdx = IDX_W'(i);
            end
        end
    end

    // Hit/skip/re-arm sequencing with registered hit flag, index and saturating count.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= ARMED;
            r_hitN     <= 1'b1;
            r_hitIdx   <= '0;
            r_hitCount <= '0;
        end else begin
            case (r_state)
                ARMED: begin
                    if (w_hitEvent) begin
                        r_state  <= HIT;
                        r_hitN   <= 1'b0;
                        r_hitIdx <= w_matchIdx;
                    end
                end
                HIT: begin
                    if (w_leaveHit) begin
                        r_state <= SKIP;
                        r_hitN  <= 1'b1;
                    end
                end
                SKIP: begin
                    if (w_instrDone) begin
                        r_state <= ARMED;
                    end
                end
                default: begin
                    r_state <= ARMED;
                    r_hitN  <= 1'b1;
                end
            endcase

            // A clear wins over an increment landing in the same cycle.
            if (i_cntClr) begin
                r_hitCount <= '0;
            end else if (w_hitEvent && !(&r_hitCount)) begin
                r_hitCount <= r_hitCount + 1'b1;
            end
        end
    end

    assign o_breakpointHitN = r_hitN;
    assign o_hitIdx         = r_hitIdx;
    assign o_hitCount       = r_hitCount;

endmodule

// File: tb/tb_breakpoint_unit.sv
// Directed bench for breakpoint_unit: single-cycle instruction stream with
// hand-computed hit flag, index and count after each relevant clock edge.
module tb_breakpoint_unit;

    localparam int ADDR_WIDTH    = 16;
    localparam int NUM_BP        = 4;
    localparam int HIT_CNT_WIDTH = 8;
    localparam int IDX_W         = 2;

    logic                     clk;
    logic                     resetn;
    logic                     breakpointEnableN;
    logic                     cpuRun;
    logic                     ctrlInstrFinishedN;
    logic [ADDR_WIDTH-1:0]    pc;
    logic                     cfgWe;
    logic [IDX_W-1:0]         cfgIdx;
    logic [ADDR_WIDTH-1:0]    cfgAddr;
    logic                     cfgValid;
    logic                     cntClr;
    logic                     hitN;
    logic [IDX_W-1:0]         hitIdx;
    logic [HIT_CNT_WIDTH-1:0] hitCount;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    breakpoint_unit #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .NUM_BP        (NUM_BP),
        .HIT_CNT_WIDTH (HIT_CNT_WIDTH)
    ) dut (
        .i_clk                (clk),
        .i_resetn             (resetn),
        .i_breakpointEnableN  (breakpointEnableN),
        .i_cpuRun             (cpuRun),
        .i_ctrlInstrFinishedN (ctrlInstrFinishedN),
        .i_pc                 (pc),
        .i_cfgWe              (cfgWe),
        .i_cfgIdx             (cfgIdx),
        .i_cfgAddr            (cfgAddr),
        .i_cfgValid           (cfgValid),
        .i_cntClr             (cntClr),
        .o_breakpointHitN     (hitN),
        .o_hitIdx             (hitIdx),
        .o_hitCount           (hitCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of CPU activity, then land 1 time unit past the edge.
    task automatic cyc(input logic [ADDR_WIDTH-1:0] p, input logic run, input logic finN);
        pc                 = p;
        cpuRun             = run;
        ctrlInstrFinishedN = finN;
        @(posedge clk);
        #1;
    endtask

    // One-cycle slot write with the CPU stalled.
    task automatic wr(input logic [IDX_W-1:0] idx, input logic [ADDR_WIDTH-1:0] a, input logic v);
        cfgWe    = 1'b1;
        cfgIdx   = idx;
        cfgAddr  = a;
        cfgValid = v;
        cyc(16'hFFFF, 1'b0, 1'b1);
        cfgWe    = 1'b0;
    endtask

    initial begin
        resetn             = 1'b0;
        breakpointEnableN  = 1'b0;
        cpuRun             = 1'b0;
        ctrlInstrFinishedN = 1'b1;
        pc                 = '0;
        cfgWe              = 1'b0;
        cfgIdx             = '0;
        cfgAddr            = '0;
        cfgValid           = 1'b0;
        cntClr             = 1'b0;

        #23;
        check("rst_hitN", 32'(hitN), 32'd1);
        check("rst_idx", 32'(hitIdx), 32'd0);
        check("rst_cnt", 32'(hitCount), 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Basic hit on slot 1 at 0x40, one cycle after its fetch strobe
        wr(2'd1, 16'h0040, 1'b1);
        cyc(16'h003D, 1'b1, 1'b0);
        cyc(16'h003E, 1'b1, 1'b0);
        cyc(16'h003F, 1'b1, 1'b0);
        check("pre_hit_hitN", 32'(hitN), 32'd1);
        cyc(16'h0040, 1'b1, 1'b0);
        exp_cnt = 1;
        check("hit1_hitN", 32'(hitN), 32'd0);
        check("hit1_idx", 32'(hitIdx), 32'd1);
        check("hit1_cnt", 32'(hitCount), 32'(exp_cnt));
        cyc(16'h0040, 1'b0, 1'b1);
        cyc(16'h0040, 1'b0, 1'b1);
        check("hit_held", 32'(hitN), 32'd0);
        wr(2'd3, 16'h0500, 1'b1);
        check("hit_cfgwr", 32'(hitN), 32'd0);

        // Forced step out of HIT, finish 0x40, then 0x41 must not hit
        cyc(16'h0040, 1'b1, 1'b1);
        check("step_hitN", 32'(hitN), 32'd1);
        cyc(16'h0040, 1'b1, 1'b0);
        cyc(16'h0041, 1'b1, 1'b0);
        check("pc41_nohit", 32'(hitN), 32'd1);

        // Returning to 0x40 re-hits
        cyc(16'h0040, 1'b1, 1'b0);
        exp_cnt = 2;
        check("rehit_hitN", 32'(hitN), 32'd0);
        check("rehit_cnt", 32'(hitCount), 32'(exp_cnt));

        // Disable during HIT -> SKIP; disabled while ARMED -> no hit, no count
        breakpointEnableN = 1'b1;
        cyc(16'h0040, 1'b0, 1'b1);
        check("dis_in_hit", 32'(hitN), 32'd1);
        cyc(16'h0040, 1'b1, 1'b0);
        cyc(16'h003F, 1'b1, 1'b0);
        cyc(16'h0040, 1'b1, 1'b0);
        check("dis_pc40_hitN", 32'(hitN), 32'd1);
        cyc(16'h0041, 1'b1, 1'b0);
        check("dis_cnt", 32'(hitCount), 32'(exp_cnt));
        breakpointEnableN = 1'b0;

        // Slots 0 and 2 both at 0x100: lowest index wins
        wr(2'd0, 16'h0100, 1'b1);
        wr(2'd2, 16'h0100, 1'b1);
        cyc(16'h00FF, 1'b1, 1'b0);
        cyc(16'h0100, 1'b1, 1'b0);
        exp_cnt = 3;
        check("prio_hitN", 32'(hitN), 32'd0);
        check("prio_idx", 32'(hitIdx), 32'd0);
        check("prio_cnt", 32'(hitCount), 32'(exp_cnt));
        cyc(16'h0100, 1'b1, 1'b1);
        cyc(16'h0100, 1'b1, 1'b0);

        // Same-cycle write is not seen; next strobe sees it
        cfgWe    = 1'b1;
        cfgIdx   = 2'd3;
        cfgAddr  = 16'h0200;
        cfgValid = 1'b1;
        cyc(16'h0200, 1'b1, 1'b0);
        cfgWe    = 1'b0;
        check("samecyc_wr", 32'(hitN), 32'd1);
        cyc(16'h0200, 1'b1, 1'b0);
        exp_cnt = 4;
        check("newslot_hitN", 32'(hitN), 32'd0);
        check("newslot_idx", 32'(hitIdx), 32'd3);
        cyc(16'h0200, 1'b1, 1'b1);
        cyc(16'h003F, 1'b1, 1'b0);

        // 260 more hits saturate the 8-bit counter
        for (int i = 0; i < 260; i++) begin
            cyc(16'h0040, 1'b1, 1'b0);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            if (i == 100) begin
                check("cnt_mid", 32'(hitCount), 32'(exp_cnt));
            end
            cyc(16'h0040, 1'b1, 1'b1);
            cyc(16'h0040, 1'b1, 1'b0);
        end
        check("cnt_sat", 32'(hitCount), 32'hFF);

        // Clear together with a new hit -> 0
        cntClr = 1'b1;
        cyc(16'h0040, 1'b1, 1'b0);
        cntClr = 1'b0;
        check("clr_hitN", 32'(hitN), 32'd0);
        check("clr_cnt", 32'(hitCount), 32'd0);

        // Async reset mid-HIT
        cyc(16'h0040, 1'b0, 1'b1);
        resetn = 1'b0;
        #2;
        check("arst_hitN", 32'(hitN), 32'd1);
        check("arst_idx", 32'(hitIdx), 32'd0);
        #2;
        resetn = 1'b1;
        cyc(16'h003F, 1'b1, 1'b0);
        cyc(16'h0040, 1'b1, 1'b0);
        check("post_rst_nohit", 32'(hitN), 32'd1);
        check("post_rst_cnt", 32'(hitCount), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
